// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - write-back queue feeding the register file write port, with two forwarding lookups
module regfile_wb_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  we_en,
    output logic [ADDR_WIDTH-1:0] WrAddr,
    output logic [DATA_WIDTH-1:0] WrDta,
    input  logic [ADDR_WIDTH-1:0] fwd_addr_a,
    input  logic [ADDR_WIDTH-1:0] fwd_addr_b,
    output logic                  fwd_hit_a,
    output logic                  fwd_hit_b,
    output logic [DATA_WIDTH-1:0] fwd_data_a,
    output logic [DATA_WIDTH-1:0] fwd_data_b,
    output logic                  empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
    logic [PW:0]           count_q, count_d;
    logic                  we_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_dta_q;

    logic protected_addr;
    logic push, pop;

    // Indices 0 and 30 are acknowledged but silently dropped.
    assign protected_addr = (in_addr == '0) || (in_addr == ADDR_WIDTH'(30));
    assign in_ready       = !rst && (count_q < DEPTH_C);
    assign push           = in_valid && in_ready && !protected_addr;
    assign pop            = (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= in_addr;
            data_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            we_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_dta_q  <= '0;
        end else begin
            count_q <= count_d;
            we_en_q <= pop;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                wr_addr_q <= addr_q[rd_ptr_q];
                wr_dta_q  <= data_q[rd_ptr_q];
            end
        end
    end

    // Scan oldest to youngest so later matches overwrite earlier ones.
    function automatic logic [DATA_WIDTH:0] lookup(input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH:0] r;
        logic [PW-1:0]       idx;
        r = '0;
        if (we_en_q && wr_addr_q == a) begin
            r = {1'b1, wr_dta_q};
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (((PW+1)'(i) < count_q) && (addr_q[idx] == a)) begin
                r = {1'b1, data_q[idx]};
            end
        end
        if (a == '0 || a == ADDR_WIDTH'(31)) begin
            r = '0;
        end
        return r;
    endfunction

    always_comb begin
        {fwd_hit_a, fwd_data_a} = lookup(fwd_addr_a);
        {fwd_hit_b, fwd_data_b} = lookup(fwd_addr_b);
    end

    assign we_en  = we_en_q;
    assign WrAddr = wr_addr_q;
    assign WrDta  = wr_dta_q;
    assign empty  = (count_q == '0) && !we_en_q;
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb/tb_regfile_wb_queue.sv - self-checking bench for regfile_wb_queue against a queue-based model
module tb_regfile_wb_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_addr = '0;
    logic [31:0] in_data = '0;
    logic        we_en;
    logic [4:0]  WrAddr;
    logic [31:0] WrDta;
    logic [4:0]  fwd_addr_a = '0;
    logic [4:0]  fwd_addr_b = '0;
    logic        fwd_hit_a, fwd_hit_b;
    logic [31:0] fwd_data_a, fwd_data_b;
    logic        empty;

    regfile_wb_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .we_en(we_en), .WrAddr(WrAddr), .WrDta(WrDta),
        .fwd_addr_a(fwd_addr_a), .fwd_addr_b(fwd_addr_b),
        .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
        .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
        .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wb_t;

    wb_t         pend[$];
    logic        m_we   = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    int          total  = 0;
    int          passed = 0;
    int          failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_fwd(input logic [4:0] a, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        if (a == 5'd0 || a == 5'd31) return;
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].a == a) begin
                h = 1'b1;
                d = pend[i].d;
                return;
            end
        end
        if (m_we && m_addr == a) begin
            h = 1'b1;
            d = m_data;
        end
    endfunction

    task automatic check_all();
        logic        ha, hb;
        logic [31:0] da, db;
        model_fwd(fwd_addr_a, ha, da);
        model_fwd(fwd_addr_b, hb, db);
        chk("in_ready", 32'(in_ready), 32'(!rst && pend.size() < DEPTH));
        chk("we_en", 32'(we_en), 32'(m_we));
        chk("WrAddr", 32'(WrAddr), 32'(m_addr));
        chk("WrDta", WrDta, m_data);
        chk("empty", 32'(empty), 32'(pend.size() == 0 && !m_we));
        chk("fwd_hit_a", 32'(fwd_hit_a), 32'(ha));
        chk("fwd_data_a", fwd_data_a, da);
        chk("fwd_hit_b", 32'(fwd_hit_b), 32'(hb));
        chk("fwd_data_b", fwd_data_b, db);
    endtask

    // One clock: drive at negedge, check, advance model on posedge, return at next negedge.
    task automatic cycle(input logic r, input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic [4:0] fa, input logic [4:0] fb);
        logic acc;
        rst = r; in_valid = v; in_addr = a; in_data = d;
        fwd_addr_a = fa; fwd_addr_b = fb;
        #1;
        check_all();
        acc = v && !r && (pend.size() < DEPTH);
        @(posedge clk);
        if (r) begin
            pend.delete();
            m_we = 1'b0; m_addr = '0; m_data = '0;
        end else begin
            if (pend.size() > 0) begin
                m_we = 1'b1;
                {m_addr, m_data} = pend.pop_front();
            end else begin
                m_we = 1'b0;
            end
            if (acc && a != 5'd0 && a != 5'd30) pend.push_back({a, d});
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_addr = 5'd5;
        @(posedge clk);
        @(negedge clk);
        cycle(1, 1, 5, 32'h55, 0, 0);
        chk("rst_we_en", 32'(we_en), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 5, 0, 5, 0);
        chk("post_rst_no_write", 32'(we_en), 32'd0);

        cycle(0, 1, 7, 32'hDEAD_BEEF, 7, 0);
        chk("lat_e1_hit", 32'(fwd_hit_a), 32'd1);
        chk("lat_e1_data", fwd_data_a, 32'hDEAD_BEEF);
        chk("lat_e1_we", 32'(we_en), 32'd0);
        cycle(0, 0, 0, 0, 7, 0);
        chk("lat_e2_we", 32'(we_en), 32'd1);
        chk("lat_e2_addr", 32'(WrAddr), 32'd7);
        chk("lat_e2_data", WrDta, 32'hDEAD_BEEF);
        chk("lat_e2_hit", 32'(fwd_hit_a), 32'd1);
        cycle(0, 0, 0, 0, 7, 0);
        chk("lat_e3_we", 32'(we_en), 32'd0);
        chk("lat_e3_hit", 32'(fwd_hit_a), 32'd0);
        cycle(0, 0, 0, 0, 7, 0);

        cycle(0, 1, 0, 32'h1, 0, 0);
        chk("prot0_empty", 32'(empty), 32'd1);
        cycle(0, 1, 30, 32'h2, 30, 0);
        chk("prot30_empty", 32'(empty), 32'd1);
        for (int i = 0; i < 2; i++) begin
            cycle(0, 0, 0, 0, 30, 0);
            chk("prot_no_we", 32'(we_en), 32'd0);
        end
        cycle(0, 1, 31, 32'h3, 0, 31);
        chk("fwd31_pending", 32'(fwd_hit_b), 32'd0);
        cycle(0, 0, 0, 0, 0, 31);
        chk("w31_issued", 32'(we_en), 32'd1);
        cycle(0, 0, 0, 0, 0, 31);

        cycle(0, 1, 3, 32'h11, 3, 3);
        cycle(0, 1, 3, 32'h22, 3, 3);
        chk("young_data", fwd_data_a, 32'h22);
        chk("young_out_first", WrDta, 32'h11);
        cycle(0, 0, 0, 0, 3, 3);
        chk("young_out_second", WrDta, 32'h22);
        chk("young_we", 32'(we_en), 32'd1);
        cycle(0, 0, 0, 0, 3, 3);

        for (int i = 1; i <= 6; i++) begin
            cycle(0, 1, 5'(i), 32'(i * 16), 5'(i), 5'(i - 1));
            chk("stream_ready", 32'(in_ready), 32'd1);
        end
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 6, 5);
        chk("stream_last", WrDta, 32'h60);

        cycle(0, 1, 12, 32'hA1, 12, 13);
        cycle(0, 1, 13, 32'hA2, 12, 13);
        chk("mid_first_issue", WrDta, 32'hA1);
        cycle(1, 1, 14, 32'hA3, 12, 13);
        chk("mid_rst_we", 32'(we_en), 32'd0);
        chk("mid_rst_addr", 32'(WrAddr), 32'd0);
        chk("mid_rst_data", WrDta, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, 13, 14);
            chk("mid_no_late_we", 32'(we_en), 32'd0);
        end

        for (int n = 0; n < 400; n++) begin
            logic [4:0] a, fa, fb;
            int sel;
            sel = $urandom_range(0, 5);
            case (sel)
                0: a = 5'd0;
                1: a = 5'd30;
                2: a = 5'd31;
                3: a = 5'd3;
                default: a = 5'($urandom_range(0, 31));
            endcase
            fa = ($urandom_range(0, 1) == 0) ? 5'd3 : 5'($urandom_range(0, 31));
            fb = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7), a, $urandom, fa, fb);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/regfile_wb_queue.md
# regfile_wb_queue

Write-back queue sitting between the execute/memory stages and the 32-entry register file write port. It accepts write-back requests through a valid/ready handshake and buffers them in a small FIFO. It drains them one per cycle onto the register file's write port (`we_en`/`WrAddr`/`WrDta`). It also exposes two forwarding lookups, so readers see writes that are still pending in the queue or the output stage.

## Interface
- `DATA_WIDTH`, 32, width of write data
- `ADDR_WIDTH`, 5, register index width
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  write-back request present
- `in_ready`  out  1  queue can accept this cycle
- `in_addr`  in  ADDR_WIDTH  destination register
- `in_data`  in  DATA_WIDTH  value to write
- `we_en`  out  1  write strobe to register file (registered)
- `WrAddr`  out  ADDR_WIDTH  write index (registered)
- `WrDta`  out  DATA_WIDTH  write data (registered)
- `fwd_addr_a`, `fwd_addr_b`  in  ADDR_WIDTH  read indices being looked up
- `fwd_hit_a`, `fwd_hit_b`  out  1  pending write exists for that index (combinational)
- `fwd_data_a`, `fwd_data_b`  out  DATA_WIDTH  youngest pending value; 0 when no hit
- `empty`  out  1  FIFO holds no entries and `we_en`=0

## Operation
- **Accept.** Accept occurs when `in_valid && in_ready`.
- **`in_ready`.** `in_ready = !rst && (count < DEPTH)`. It is combinational on `count` only and never depends on a same-cycle pop.
- **Protected indices.**
  - An accepted request with `in_addr` = 0 or 30 completes the handshake but is discarded. It is not enqueued, and `count` is unchanged.
  - These indices are never written.
- **Enqueue.** Any other accepted request is written at `wr_ptr`, and `wr_ptr` increments mod DEPTH.
- **Pop.** Each cycle with `count > 0`:
  - The head at `rd_ptr` is loaded into `WrAddr`/`WrDta` with `we_en`=1.
  - `rd_ptr` increments mod DEPTH.
- **Idle output.** When `count = 0`, `we_en` goes to 0. `WrAddr`/`WrDta` hold their last values.
- **Simultaneous push and pop.** `count` is unchanged and both pointers advance.
  - When `count = DEPTH`, no push occurs (`in_ready`=0). A pop still happens.
- **Forwarding, per port.**
  - Candidates are all valid FIFO entries plus the output stage when `we_en`=1. Same-cycle `in_*` is not a candidate.
  - The youngest match wins. FIFO entries are newer than the output stage, and the entry nearest `wr_ptr` is newest.
  - Lookup addresses 0 and 31 never hit, because the register file reads them as zero.
- **Ordering.** Writes reach the register file in acceptance order. Duplicates to the same index are all issued, not merged.

## Timing
- **Reset (synchronous, on rising edge with `rst`=1).**
  - `count`=0, `rd_ptr`=`wr_ptr`=0.
  - `we_en`=0, `WrAddr`=0, `WrDta`=0.
  - `fwd_hit_*`=0, `fwd_data_*`=0, `empty`=1.
  - Queued and in-flight writes are dropped, including a reset asserted mid-drain.
- **Latency into an empty queue.**
  - The request is accepted at edge E.
  - It is popped at edge E+1, so `we_en`=1 in the cycle after E+1.
  - The register file is written at edge E+2.
- **Forward coverage.** `fwd_hit` is 1 for that index from the cycle after E through the cycle before E+2, with no gap.
- **Throughput.** One write per cycle sustained. A back-to-back stream with `in_valid` held high never deasserts `in_ready`.
- **Full queue.** `in_ready` returns to 1 in the cycle after the first pop from the full state.
- **Pointer wrap.** `DEPTH` = 2^k, so pointers wrap naturally. `count` is k+1 bits.

## Test plan
- **Reset values.** Assert `rst` for 2 cycles with `in_valid`=1, `in_addr`=5 → `in_ready`=0, `we_en`=0, `empty`=1. No write appears after release.
- **Single write latency.** Accept (addr 7, data 0xDEAD_BEEF) at edge E → `we_en`=1, `WrAddr`=7, `WrDta`=0xDEADBEEF for exactly one cycle after E+1. `fwd_addr_a`=7 hits with 0xDEADBEEF in cycles E+1 and E+2 (the cycle after E and the cycle after E+1), then `fwd_hit_a`=0.
- **Protected indices.**
  - Send addr 0 (data 0x1) then addr 30 (data 0x2), each accepted → `we_en` never rises and `empty` stays 1.
  - Lookup with `fwd_addr_b`=31 while addr 31 (data 0x3) is pending → `fwd_hit_b`=0.
- **Youngest-wins forwarding.** Hold the output stage busy and queue addr 3 = 0x11, then addr 3 = 0x22 → `fwd_data_a`=0x22. Register file writes occur as 0x11 then 0x22 on consecutive cycles.
- **Full and wrap.**
  - Push 6 requests back-to-back (addr 1..6, data = addr×0x10) → no stall, since a pop occurs every cycle.
  - Force fill by blocking nothing, then check `count` never exceeds 4.
  - Drain order is 1..6 across pointer wrap.
- **Reset mid-drain.** Queue 3 writes, then assert `rst` after the first issues → the 2nd and 3rd never appear on `we_en`, and all outputs return to their reset values.
